// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional end-of-packet marking is enabled by defining FIFO_STREAM_READER_PKT_LAST_EN.
module fifo_stream_reader #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16,
  parameter int PKT_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             fifo_cs,
  output logic             fifo_re,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] beat_count
);

  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [CNT_W-1:0] r_beatCount;

  logic             w_pop;
  logic [2:0]       w_level;
  logic             w_room;

  assign w_pop   = m_valid && m_ready;
  // Words already owned by this stage (buffered or on the FIFO read bus), net of this cycle's pop.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room  = (w_level < 3'd2);

  assign fifo_cs    = enable;
  assign fifo_re    = enable && !fifo_empty && !reset && w_room;
  assign m_data     = r_buf0;
  assign m_valid    = (r_occ != 2'd0);
  assign beat_count = r_beatCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_beatCount <= '0;
    end else begin
      r_inflight <= fifo_re;
      if (w_pop) begin
        r_beatCount <= r_beatCount + 1'b1;
      end
      case ({r_inflight, w_pop})
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_dout;
          end else begin
            r_buf0 <= fifo_dout;
          end
        end
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= fifo_dout;
          end else begin
            r_buf1 <= fifo_dout;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FIFO_STREAM_READER_PKT_LAST_EN
  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PKT_W-1:0] LAST_IDX = PKT_W'(PKT_LEN - 1);

  logic [PKT_W-1:0] r_pktIdx;

  // The head word's position in its packet equals the number of beats already sent, modulo PKT_LEN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pktIdx <= '0;
    end else if (w_pop) begin
      r_pktIdx <= (r_pktIdx == LAST_IDX) ? '0 : r_pktIdx + 1'b1;
    end
  end

  assign m_last = m_valid && (r_pktIdx == LAST_IDX);
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: behavioural FIFO plus an in-order scoreboard.
// Define FIFO_STREAM_READER_PKT_LAST_EN for both files to exercise packet marking.
module tb_fifo_stream_reader;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 16;
  localparam int PKT_LEN = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             fifoEmpty = 1'b1;
  logic [WIDTH-1:0] fifoDout = '0;
  logic             mReady = 1'b0;
  logic             fifoCs;
  logic             fifoRe;
  logic [WIDTH-1:0] mData;
  logic             mValid;
  logic             mLast;
  logic [CNT_W-1:0] beatCount;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_cs(fifoCs), .fifo_re(fifoRe), .fifo_empty(fifoEmpty), .fifo_dout(fifoDout),
    .m_data(mData), .m_valid(mValid), .m_ready(mReady), .m_last(mLast),
    .beat_count(beatCount)
  );

  int vectorsApplied = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] fifoQ[$];
  logic [WIDTH-1:0] expQ[$];
  logic [CNT_W-1:0] expBeat = '0;
  int pktIdx = 0;
  int outstanding = 0;
  int readsIssued = 0;
  int lastSeen = 0;

  logic             sValid, sRe, sLast, sBeat;
  logic [WIDTH-1:0] sData;
  logic [CNT_W-1:0] sBc;
  logic             prevStall = 1'b0;
  logic [WIDTH-1:0] prevData = '0;
  logic             prevLast = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] w);
    fifoQ.push_back(w);
    expQ.push_back(w);
  endtask

  // One clock: inputs are already set (we sit just after a negedge), sample, check, then model the edge.
  task automatic applyStimulus();
    logic expLast;
    logic [WIDTH-1:0] expWord;
    fifoEmpty = (fifoQ.size() == 0);
    #1;
    sValid = mValid; sRe = fifoRe; sData = mData; sLast = mLast; sBc = beatCount;
    sBeat  = mValid && mReady && !reset;
    checkOutput("cs", {63'd0, fifoCs}, {63'd0, enable});
    checkOutput("reLegal", {63'd0, fifoRe && !(enable && !fifoEmpty && !reset)}, 64'd0);
    checkOutput("beatCount", {48'd0, beatCount}, {48'd0, expBeat});
    if (prevStall) begin
      checkOutput("holdValid", {63'd0, mValid}, 64'd1);
      checkOutput("holdData", {32'd0, mData}, {32'd0, prevData});
      checkOutput("holdLast", {63'd0, mLast}, {63'd0, prevLast});
    end
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
    expLast = (pktIdx == PKT_LEN - 1);
`else
    expLast = 1'b0;
`endif
    if (sBeat) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousBeat", 64'd1, 64'd0);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("data", {32'd0, mData}, {32'd0, expWord});
      end
      checkOutput("last", {63'd0, mLast}, {63'd0, expLast});
      if (mLast) lastSeen++;
    end
    @(posedge clk);
    if (reset) begin
      fifoQ.delete();
      expQ.delete();
      fifoDout <= '0;
      outstanding = 0;
      expBeat = '0;
      pktIdx = 0;
      prevStall = 1'b0;
    end else begin
      if (sRe && fifoQ.size() > 0) begin
        fifoDout <= fifoQ.pop_front();
        outstanding++;
        readsIssued++;
      end
      if (sBeat) begin
        outstanding--;
        expBeat = expBeat + 1'b1;
        pktIdx = (pktIdx + 1) % PKT_LEN;
      end
      checkOutput("outstanding", {63'd0, outstanding <= 2}, 64'd1);
      prevStall = sValid && !mReady;
      prevData  = sData;
      prevLast  = sLast;
    end
    @(negedge clk);
  endtask

  task automatic resetCycle();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    logic found;
    @(negedge clk);

    // Reset held with a populated FIFO: nothing may be read or presented.
    enable = 1'b1; mReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) pushWord(32'hF000 + k);
      applyStimulus();
      checkOutput("rstValid", {63'd0, sValid}, 64'd0);
      checkOutput("rstRe", {63'd0, sRe}, 64'd0);
    end
    reset = 1'b0;
    applyStimulus();
    checkOutput("relValid", {63'd0, sValid}, 64'd0);
    checkOutput("relRe", {63'd0, sRe}, 64'd0);
    checkOutput("relBc", {48'd0, sBc}, 64'd0);

    // Streaming latency and full throughput.
    resetCycle();
    for (int k = 1; k <= 8; k++) pushWord(k);
    applyStimulus();
    checkOutput("latRe", {63'd0, sRe}, 64'd1);
    checkOutput("latValid0", {63'd0, sValid}, 64'd0);
    applyStimulus();
    checkOutput("latValid1", {63'd0, sValid}, 64'd0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus();
      checkOutput("thruValid", {63'd0, sValid}, 64'd1);
      checkOutput("thruData", {32'd0, sData}, k);
    end
    applyStimulus();
    checkOutput("thruEnd", {63'd0, sValid}, 64'd0);
    checkOutput("thruBc", {48'd0, sBc}, 64'd8);

    // Backpressure mid-stream.
    resetCycle();
    for (int k = 1; k <= 8; k++) pushWord(k);
    for (int c = 0; c < 4; c++) applyStimulus();
    mReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("stallRe", {63'd0, sRe}, 64'd0);
      checkOutput("stallValid", {63'd0, sValid}, 64'd1);
    end
    mReady = 1'b1;
    for (int c = 0; c < 12; c++) applyStimulus();
    checkOutput("stallBc", {48'd0, sBc}, 64'd8);

    // Enable drop right after a read: in-flight word still delivered, no new reads.
    resetCycle();
    readsIssued = 0;
    for (int k = 1; k <= 6; k++) pushWord(32'h100 + k);
    for (int c = 0; c < 3; c++) applyStimulus();
    checkOutput("dropRe", {63'd0, sRe}, 64'd1);
    enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus();
      checkOutput("dropNoRe", {63'd0, sRe}, 64'd0);
    end
    checkOutput("dropDrain", {48'd0, sBc}, readsIssued);
    checkOutput("dropRemain", expQ.size(), 64'd3);
    enable = 1'b1;
    for (int c = 0; c < 8; c++) applyStimulus();
    checkOutput("dropBc", {48'd0, sBc}, 64'd6);

    // Reset while the buffer is full.
    resetCycle();
    for (int k = 1; k <= 8; k++) pushWord(32'h200 + k);
    for (int c = 0; c < 4; c++) applyStimulus();
    mReady = 1'b0;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    mReady = 1'b1;
    for (int k = 0; k < 4; k++) pushWord(32'hA0 + k);
    applyStimulus();
    checkOutput("midRstValid", {63'd0, sValid}, 64'd0);
    checkOutput("midRstBc", {48'd0, sBc}, 64'd0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      applyStimulus();
      if (sValid) begin
        checkOutput("midRstFirst", {32'd0, sData}, 64'hA0);
        found = 1'b1;
      end
    end
    checkOutput("midRstTimeout", {63'd0, found}, 64'd1);

    // Ten-word packet stream.
    resetCycle();
    lastSeen = 0;
    for (int k = 0; k < 10; k++) pushWord(32'h300 + k);
    for (int c = 0; c < 14; c++) applyStimulus();
    checkOutput("pktBc", {48'd0, sBc}, 64'd10);
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
    checkOutput("pktLastCount", lastSeen, 64'd2);
`else
    checkOutput("pktLastCount", lastSeen, 64'd0);
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 99) < 2);
      enable = ($urandom_range(0, 7) != 0);
      mReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && fifoQ.size() < 16) pushWord($urandom);
      applyStimulus();
    end
    reset = 1'b0; enable = 1'b1; mReady = 1'b1;
    for (int c = 0; c < 40; c++) applyStimulus();
    checkOutput("drainAll", expQ.size(), 64'd0);
    checkOutput("drainOutstanding", outstanding, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
